// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, IV, FSM state type and the FIPS 180-4 logic functions.
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// sha256_compress_if: start/done handshake and data bus of the compression controller.
interface sha256_compress_if;
    logic         start;
    logic [511:0] block;
    logic [255:0] hash_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [255:0] hash_out;

    modport slave (input start, block, hash_in, output ready, busy, done, hash_out);
    modport master(output start, block, hash_in, input ready, busy, done, hash_out);
endinterface

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round; s_i/s_o word 0 is a, word 7 is h.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [0:7][31:0] s_i,
    input  logic [31:0]      k_i,
    input  logic [31:0]      w_i,
    output logic [0:7][31:0] s_o
);
    logic [31:0] t1, t2;

    always_comb begin
        t1 = s_i[7] + bsig1(s_i[4]) + ch(s_i[4], s_i[5], s_i[6]) + k_i + w_i;
        t2 = bsig0(s_i[0]) + maj(s_i[0], s_i[1], s_i[2]);
        s_o[0]   = t1 + t2;
        s_o[1:3] = s_i[0:2];
        s_o[4]   = s_i[3] + t1;
        s_o[5:7] = s_i[4:6];
    end
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: 64-round SHA-256 compression, one round per clock, start/done handshake.
// Working state, captured chaining value and result are kept as word arrays with word 0 = a / H0.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    sha256_compress_if.slave         bus
);
    state_e           state_q, state_d;
    logic [5:0]       t_q, t_d;
    logic [0:7][31:0] st_q, st_d, st_next;
    logic [0:7][31:0] hv_q, hv_d;
    logic [0:7][31:0] hash_q, hash_d;
    logic [0:15][31:0] w_q, w_d;
    logic             done_q, done_d;
    logic [31:0]      w_new;

    sha256_round u_round (.s_i(st_q), .k_i(K[t_q]), .w_i(w_q[0]), .s_o(st_next));

    assign w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        st_d    = st_q;
        hv_d    = hv_q;
        hash_d  = hash_q;
        w_d     = w_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                st_d    = bus.hash_in;
                hv_d    = bus.hash_in;
                w_d     = bus.block;
                t_d     = 6'd0;
                state_d = ROUND;
            end
            ROUND: begin
                st_d    = st_next;
                w_d     = {w_q[1:15], w_new};
                t_d     = t_q + 6'd1;
                state_d = (t_q == 6'd63) ? FINAL : ROUND;
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) hash_d[i] = hv_q[i] + st_q[i];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            st_q    <= '0;
            hv_q    <= '0;
            hash_q  <= '0;
            w_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            st_q    <= st_d;
            hv_q    <= hv_d;
            hash_q  <= hash_d;
            w_q     <= w_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.hash_out = hash_q;
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: known-answer vectors, handshake timing, reset abort and random blocks vs a reference model.
module tb_sha256_compress;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total = 0;

    sha256_compress_if bus();
    sha256_compress dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] ABC_HASH  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_HASH= 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_HASH  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Reference: full 64-word message expansion, then the round loop, then the feed-forward add.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Called with ready=1, #1 after a clock edge; scrambles the inputs after the accept edge.
    task automatic run_block(input logic [511:0] blk, input logic [255:0] hin,
                             output logic [255:0] res, output int lat, output int low);
        bus.block = blk;
        bus.hash_in = hin;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.block = rand512();
        bus.hash_in = rand256();
        lat = 0;
        low = bus.ready ? 0 : 1;
        while (!bus.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (!bus.ready) low++;
        end
        res = bus.hash_out;
    endtask

    initial begin
        logic [255:0] res, mid, h, exp;
        int lat, low, cyc, last, lowrun, ndone, bad;
        logic [511:0] blk;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.block = '0;
        bus.hash_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ready", 256'(bus.ready), 256'd1);
        check("rst_busy", 256'(bus.busy), 256'd0);
        check("rst_done", 256'(bus.done), 256'd0);
        check("rst_hash", bus.hash_out, 256'd0);

        run_block(ABC_BLK, IV, res, lat, low);
        check("abc_hash", res, ABC_HASH);
        check("abc_latency", 256'(lat), 256'd65);
        check("abc_ready_low", 256'(low), 256'd65);
        check("abc_ready_at_done", 256'(bus.ready), 256'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 256'(bus.done), 256'd0);

        run_block(EMPTY_BLK, IV, res, lat, low);
        check("empty_hash", res, EMPTY_HASH);

        run_block(TWO_BLK1, IV, mid, lat, low);
        check("two_mid_model", mid, ref_compress(IV, TWO_BLK1));
        run_block(TWO_BLK2, mid, res, lat, low);
        check("two_final", res, TWO_HASH);

        // start held high (toggled randomly while busy) with scrambled inputs between accepts
        bus.start = 1'b1;
        bus.block = ABC_BLK;
        bus.hash_in = IV;
        ndone = 0; last = -1; cyc = 0; lowrun = 0;
        while (ndone < 3 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (!bus.ready) lowrun++;
            if (bus.done) begin
                check("held_hash", bus.hash_out, ABC_HASH);
                check("held_ready_low", 256'(lowrun), 256'd65);
                if (last >= 0) check("held_period", 256'(cyc - last), 256'd66);
                lowrun = 0;
                last = cyc;
                ndone++;
            end
            if (bus.ready) begin
                bus.block = ABC_BLK;
                bus.hash_in = IV;
                bus.start = (ndone < 3);
            end else begin
                bus.block = rand512();
                bus.hash_in = rand256();
                bus.start = 1'($urandom_range(0, 1));
            end
        end
        bus.start = 1'b0;
        check("held_done_count", 256'(ndone), 256'd3);

        // reset while the round with t=30 is pending
        bus.block = ABC_BLK;
        bus.hash_in = IV;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ready", 256'(bus.ready), 256'd1);
        check("abort_busy", 256'(bus.busy), 256'd0);
        check("abort_done", 256'(bus.done), 256'd0);
        check("abort_hash", bus.hash_out, 256'd0);
        bad = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus.done) bad++;
        end
        check("abort_no_done", 256'(bad), 256'd0);
        run_block(ABC_BLK, IV, res, lat, low);
        check("abort_rerun_hash", res, ABC_HASH);
        check("abort_rerun_latency", 256'(lat), 256'd65);

        // idle hold after done
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (bus.done || !bus.ready || bus.busy) bad++;
        end
        check("idle_flags", 256'(bad), 256'd0);
        check("idle_hash", bus.hash_out, ABC_HASH);

        for (int n = 0; n < 6; n++) begin
            blk = rand512();
            h = rand256();
            exp = ref_compress(h, blk);
            run_block(blk, h, res, lat, low);
            check($sformatf("rand%0d_hash", n), res, exp);
            check($sformatf("rand%0d_latency", n), 256'(lat), 256'd65);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
